// File: rtl/instr_stream_encoder.sv
// Packs mnemonic + fields into 32-bit MIPS words and streams them into IM through a registered write port.
// Optional ENC_FIELD_CHECK_EN: reject (err pulse) words whose unused fields are non-zero.
module instr_stream_encoder #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [25:0]       in_imm,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FULL} state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_XOR = 4'd2,  OP_JR   = 4'd3,
    OP_JALR = 4'd4,  OP_SLL  = 4'd5,  OP_ORI = 4'd6,  OP_LW   = 4'd7,
    OP_SW   = 4'd8,  OP_BEQ  = 4'd9,  OP_LUI = 4'd10, OP_JAL  = 4'd11,
    OP_J    = 4'd12, OP_LB   = 4'd13, OP_BGTZ = 4'd14, OP_ADDI = 4'd15
  } op_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e          state;
  logic [31:0]     enc_word;
  logic            word_ok;
  logic            accept;
  logic [ADDR_W:0] count_inc;

  assign in_ready  = (state == S_RUN) && (count < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign count_inc = count + 1'b1;

  always_comb begin
    enc_word = '0;
    case (op_e'(in_op))
      OP_ADD:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h20};
      OP_SUB:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h22};
      OP_XOR:  enc_word = {6'h00, in_rs, in_rt, in_rd, 5'b0, 6'h26};
      OP_JR:   enc_word = {6'h00, in_rs, 15'b0, 6'h08};
      OP_JALR: enc_word = {6'h00, in_rs, 5'b0, in_rd, 5'b0, 6'h09};
      OP_SLL:  enc_word = {6'h00, 5'b0, in_rt, in_rd, in_shamt, 6'h00};
      OP_ORI:  enc_word = {6'h0D, in_rs, in_rt, in_imm[15:0]};
      OP_LW:   enc_word = {6'h23, in_rs, in_rt, in_imm[15:0]};
      OP_SW:   enc_word = {6'h2B, in_rs, in_rt, in_imm[15:0]};
      OP_BEQ:  enc_word = {6'h04, in_rs, in_rt, in_imm[15:0]};
      OP_LUI:  enc_word = {6'h0F, 5'b0, in_rt, in_imm[15:0]};
      OP_JAL:  enc_word = {6'h03, in_imm};
      OP_J:    enc_word = {6'h02, in_imm};
      OP_LB:   enc_word = {6'h20, in_rs, in_rt, in_imm[15:0]};
      OP_BGTZ: enc_word = {6'h07, in_rs, 5'b0, in_imm[15:0]};
      OP_ADDI: enc_word = {6'h08, in_rs, in_rt, in_imm[15:0]};
      default: enc_word = '0;
    endcase
  end

`ifdef ENC_FIELD_CHECK_EN
  logic err_q;

  // A field is "unused" when the chosen op does not place it into the word.
  always_comb begin
    word_ok = 1'b1;
    case (op_e'(in_op))
      OP_ADD, OP_SUB, OP_XOR:
        word_ok = (in_shamt == '0) && (in_imm == '0);
      OP_JR:
        word_ok = (in_rt == '0) && (in_rd == '0) && (in_shamt == '0) && (in_imm == '0);
      OP_JALR:
        word_ok = (in_rt == '0) && (in_shamt == '0) && (in_imm == '0);
      OP_SLL:
        word_ok = (in_rs == '0) && (in_imm == '0);
      OP_LUI:
        word_ok = (in_rs == '0) && (in_rd == '0) && (in_shamt == '0) && (in_imm[25:16] == '0);
      OP_BGTZ:
        word_ok = (in_rt == '0) && (in_rd == '0) && (in_shamt == '0) && (in_imm[25:16] == '0);
      OP_JAL, OP_J:
        word_ok = (in_rs == '0) && (in_rt == '0) && (in_rd == '0) && (in_shamt == '0);
      default:
        word_ok = (in_rd == '0) && (in_shamt == '0) && (in_imm[25:16] == '0);
    endcase
  end

  assign err = err_q;
`else
  assign word_ok = 1'b1;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      done     <= 1'b0;
      full     <= 1'b0;
`ifdef ENC_FIELD_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      im_we <= 1'b0;
`ifdef ENC_FIELD_CHECK_EN
      err_q <= 1'b0;
`endif
      if (start) begin
        state <= S_RUN;
        count <= '0;
        done  <= 1'b0;
        full  <= 1'b0;
      end else if (state == S_RUN) begin
        if (accept && word_ok) begin
          im_we    <= 1'b1;
          im_addr  <= count[ADDR_W-1:0];
          im_wdata <= enc_word;
          count    <= count_inc;
        end
`ifdef ENC_FIELD_CHECK_EN
        if (accept && !word_ok)
          err_q <= 1'b1;
`endif
        // finish takes priority over filling the last slot
        if (finish) begin
          state <= S_DONE;
          done  <= 1'b1;
        end else if (accept && word_ok && (count_inc == DEPTH_C)) begin
          state <= S_FULL;
          full  <= 1'b1;
        end
      end
    end
  end

endmodule
